instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch front end. Owns the PC and fetches words from instruction memory over a req/ack handshake.
- Presents the fetched instruction, with opcode and funct pre-split, to the control decoder.
- Takes the decoder/ALU outcome (jump, branch type, zero flag) back to compute the next PC.
- Multi-cycle style: one instruction is held until the downstream stage signals completion.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset (word aligned).
- CNT_W, 32, width of the fetched-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- imem_req  out  1  fetch request; held high until ack.
- imem_addr  out  32  fetch address, equals pc; stable while imem_req=1.
- imem_ack  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- instr_valid  out  1  instr/pc hold a fetched instruction awaiting completion.
- pc  out  32  address of instr.
- pc_plus4  out  32  pc+4.
- next_en  in  1  one-cycle pulse: current instruction done; qualifies jump/Branch/Zero.
- jump  in  1  take J-type target.
- Branch  in  2  01=beq, 10=bne, 00/11=no branch.
- Zero  in  1  ALU zero flag for the current instruction.
- fetch_cnt  out  CNT_W  instructions accepted from imem since reset.

Behaviour:
- Reset values (async, immediate):
  - state=BOOT, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_cnt=0.
  - opcode/funct/pc_plus4 follow instr/pc combinationally.
- States: BOOT, FETCH, HOLD.
- BOOT:
  - imem_req=0.
  - Unconditionally goes to FETCH on the next edge. The first request is seen exactly 1 cycle after rst deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On an edge with imem_ack=1: instr<=imem_rdata, instr_valid<=1, fetch_cnt<=fetch_cnt+1 (wraps at 2^CNT_W), go to HOLD.
  - next_en is ignored in FETCH.
- HOLD:
  - imem_req=0, instr_valid=1, instr and pc stable.
  - imem_ack is ignored (stray or late ack has no effect).
  - On an edge with next_en=1: pc<=npc, instr_valid<=0, go to FETCH. The new request appears the cycle after next_en.
- Next-PC selection, priority high to low:
  - jump=1: npc={pc_plus4[31:28], instr[25:0], 2'b00}.
  - Branch=01 and Zero=1, or Branch=10 and Zero=0: npc=pc_plus4+{{14{instr[15]}},instr[15:0],2'b00}.
  - Otherwise (including Branch=11): npc=pc_plus4.
- Arithmetic: all additions are 32-bit modulo 2^32; no overflow flag. pc[1:0] is forced 0 on every load.
- Latency:
  - ack at edge N gives instr_valid=1 after edge N.
  - next_en at edge M gives instr_valid=0 and the new pc after edge M; imem_req=1 in cycle M+1.
- Simultaneous events:
  - imem_ack and next_en together in FETCH: ack is taken, next_en is dropped.
  - rst has priority over every event at any point.
- Reset mid-fetch: imem_req drops immediately. An outstanding ack arriving during or after reset (while in BOOT) is ignored. Fetch restarts at RESET_PC.

Test Plan:
- Reset/boot:
  - Stimulus: rst high, release; ack with rdata=32'h3408_0005.
  - Required: pc=0x3000, imem_req=0 while rst high. imem_req=1 with addr 0x3000 one cycle after release. After the ack edge: instr_valid=1, opcode=6'h0D, funct=6'h05, fetch_cnt=1.
- Sequential:
  - Stimulus: next_en with jump=0, Branch=00.
  - Required: pc=0x3004, instr_valid=0, imem_addr=0x3004 next cycle. 3 more fetches give fetch_cnt=4.
- beq at pc 0x3008, instr[15:0]=16'hFFFF:
  - Branch=01, Zero=1: next pc=0x3008.
  - Branch=01, Zero=0: next pc=0x300C.
- bne at pc 0x3000, imm=16'h0003:
  - Branch=10, Zero=0: next pc=0x3010.
  - Branch=10, Zero=1: next pc=0x3004.
  - Branch=11: next pc=0x3004.
- Jump at pc 0x3000, instr[25:0]=26'h0000C03:
  - Next pc=0x0000300C.
  - Same with Branch=01, Zero=1: still 0x0000300C (jump wins).
- Protocol robustness:
  - next_en pulsed during FETCH: no pc change.
  - Ack pulsed during HOLD: instr unchanged.
  - rst asserted while waiting for ack, then ack arrives: imem_req=0 at once, ack ignored, fetch_cnt=0, refetch from 0x3000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches over a req/ack handshake
// and holds each instruction until the downstream stage signals completion.
//
// state | meaning
// BOOT  | post-reset idle cycle, no request issued
// FETCH | imem_req high at pc, waiting for imem_ack
// HOLD  | instruction latched, waiting for next_en
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             next_en,
  input  logic             jump,
  input  logic [1:0]       Branch,
  input  logic             Zero,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] npc;
  logic [31:0] br_off;
  logic        br_taken;
  logic        take_ack;
  logic        take_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    take_ack  = 1'b0;
    take_next = 1'b0;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          take_ack = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (next_en) begin
          take_next = 1'b1;
          state_d   = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
  // Branch=11 is deliberately treated as "no branch"
  assign br_taken  = ((Branch == 2'b01) && Zero) || ((Branch == 2'b10) && !Zero);

  always_comb begin
    if (jump)          npc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (br_taken) npc = pc_plus4 + br_off;
    else               npc = pc_plus4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= {RESET_PC[31:2], 2'b00};
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      fetch_cnt   <= '0;
    end else if (take_ack) begin
      instr       <= imem_rdata;
      instr_valid <= 1'b1;
      fetch_cnt   <= fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (take_next) begin
      pc          <= {npc[31:2], 2'b00};
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: boot, sequential flow,
// branch/jump next-PC selection and handshake robustness.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        next_en = 1'b0;
  logic        jump = 1'b0;
  logic [1:0]  Branch = 2'b00;
  logic        Zero = 1'b0;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .funct(funct),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .next_en(next_en), .jump(jump), .Branch(Branch), .Zero(Zero),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a request, then returns word on a one-cycle ack.
  task automatic fetch(input logic [31:0] word);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_timeout: imem_req=%b required 1", imem_req);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
  endtask

  task automatic complete(input logic j, input logic [1:0] br, input logic z);
    next_en = 1'b1;
    jump    = j;
    Branch  = br;
    Zero    = z;
    tick();
    next_en = 1'b0;
    jump    = 1'b0;
    Branch  = 2'b00;
    Zero    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h required 00003000", pc); end
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", imem_req); end
    checks++;
    if (instr_valid !== 1'b0 || fetch_cnt !== 32'd0 || instr !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs: valid=%b cnt=%0d instr=%h required 0/0/0", instr_valid, fetch_cnt, instr);
    end
    rst = 1'b0;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b required 0", imem_req); end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h required 1/00003000", imem_req, imem_addr);
    end
    fetch(32'h3408_0005);
    checks++;
    if (instr_valid !== 1'b1 || opcode !== 6'h0D || funct !== 6'h05 || fetch_cnt !== 32'd1) begin
      errors++;
      $display("FAIL first_ack: valid=%b op=%h fn=%h cnt=%0d required 1/0d/05/1", instr_valid, opcode, funct, fetch_cnt);
    end
    checks++;
    if (imem_req !== 1'b0 || pc_plus4 !== 32'h3004) begin
      errors++;
      $display("FAIL hold_req: req=%b pc_plus4=%h required 0/00003004", imem_req, pc_plus4);
    end
  endtask

  task automatic test_sequential();
    complete(1'b0, 2'b00, 1'b0);
    checks++;
    if (pc !== 32'h3004 || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3004) begin
      errors++;
      $display("FAIL seq_next: pc=%h valid=%b req=%b addr=%h required 00003004/0/1/00003004", pc, instr_valid, imem_req, imem_addr);
    end
    fetch(32'h0000_0020);
    complete(1'b0, 2'b00, 1'b0);
    fetch(32'h0000_0021);
    complete(1'b0, 2'b00, 1'b0);
    fetch(32'h0000_0022);
    checks++;
    if (fetch_cnt !== 32'd4 || pc !== 32'h300C) begin
      errors++;
      $display("FAIL seq_count: cnt=%0d pc=%h required 4/0000300c", fetch_cnt, pc);
    end
  endtask

  task automatic test_beq();
    do_reset();
    fetch(32'h0);
    complete(1'b0, 2'b00, 1'b0);
    fetch(32'h0);
    complete(1'b0, 2'b00, 1'b0);
    fetch(32'h1000_FFFF);
    complete(1'b0, 2'b01, 1'b1);
    checks++;
    if (pc !== 32'h3008) begin errors++; $display("FAIL beq_taken: got %h required 00003008", pc); end
    fetch(32'h1000_FFFF);
    complete(1'b0, 2'b01, 1'b0);
    checks++;
    if (pc !== 32'h300C) begin errors++; $display("FAIL beq_not_taken: got %h required 0000300c", pc); end
  endtask

  task automatic test_bne();
    logic [1:0] br [4] = '{2'b10, 2'b10, 2'b11, 2'b11};
    logic       zz [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp [4] = '{32'h3010, 32'h3004, 32'h3004, 32'h3004};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      fetch(32'h1400_0003);
      complete(1'b0, br[i], zz[i]);
      checks++;
      if (pc !== exp[i]) begin
        errors++;
        $display("FAIL bne_case%0d: Branch=%b Zero=%b pc=%h required %h", i, br[i], zz[i], pc, exp[i]);
      end
    end
  endtask

  task automatic test_jump();
    do_reset();
    fetch(32'h0800_0C03);
    complete(1'b1, 2'b00, 1'b0);
    checks++;
    if (pc !== 32'h300C) begin errors++; $display("FAIL jump_plain: got %h required 0000300c", pc); end
    do_reset();
    fetch(32'h0800_0C03);
    complete(1'b1, 2'b01, 1'b1);
    checks++;
    if (pc !== 32'h300C) begin errors++; $display("FAIL jump_priority: got %h required 0000300c", pc); end
  endtask

  task automatic test_robustness();
    do_reset();
    fetch(32'h1111_1111);
    complete(1'b0, 2'b00, 1'b0);
    // stray next_en while waiting for ack
    next_en = 1'b1;
    jump    = 1'b1;
    tick();
    next_en = 1'b0;
    jump    = 1'b0;
    checks++;
    if (pc !== 32'h3004 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL next_in_fetch: pc=%h req=%b required 00003004/1", pc, imem_req);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h2222_2222;
    next_en    = 1'b1;
    tick();
    imem_ack   = 1'b0;
    next_en    = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || pc !== 32'h3004 || instr !== 32'h2222_2222) begin
      errors++;
      $display("FAIL ack_and_next: valid=%b pc=%h instr=%h required 1/00003004/22222222", instr_valid, pc, instr);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h3333_3333;
    tick();
    imem_ack   = 1'b0;
    checks++;
    if (instr !== 32'h2222_2222 || fetch_cnt !== 32'd2 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL ack_in_hold: instr=%h cnt=%0d valid=%b required 22222222/2/1", instr, fetch_cnt, instr_valid);
    end
    complete(1'b0, 2'b00, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== 32'h3000) begin
      errors++;
      $display("FAIL reset_mid_fetch: req=%b pc=%h required 0/00003000", imem_req, pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h4444_4444;
    tick();
    rst = 1'b0;
    tick();
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || fetch_cnt !== 32'd0 || instr !== 32'd0) begin
      errors++;
      $display("FAIL late_ack: valid=%b cnt=%0d instr=%h required 0/0/0", instr_valid, fetch_cnt, instr);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      errors++;
      $display("FAIL refetch: req=%b addr=%h required 1/00003000", imem_req, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_beq();
    test_bne();
    test_jump();
    test_robustness();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
